// File: rtl/sub_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sub_arbiter_pkg
// Shared definitions for the sub_arbiter slice: the sequencer state encoding
// and the requester-ID width helper used to size ID buses.
// -----------------------------------------------------------------------------
package sub_arbiter_pkg;

    // Sequencer states: grant/latch, subtract, present result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int num_req);
        if (num_req <= 2) begin
            return 1;
        end else begin
            return $clog2(num_req);
        end
    endfunction

endpackage

// File: rtl/sub_arbiter_if.sv
// -----------------------------------------------------------------------------
// sub_arbiter_if
// Bundles the requester-side and response-side handshakes of sub_arbiter.
//   req_valid/req_ready : per-requester operand handshake (ready is one-hot)
//   req_a/req_b         : flattened operand pairs, requester i at [i*DW +: DW]
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_diff     : served requester index and a - b mod 2^DW
//   rsp_borrow          : a < b flag, only when SUB_ARBITER_BORROW_EN is defined
// Modports: master = client side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface sub_arbiter_if #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int IDW       = sub_arbiter_pkg::id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*DATAWIDTH-1:0] req_a;
    logic [NUM_REQ*DATAWIDTH-1:0] req_b;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [IDW-1:0]               rsp_id;
    logic [DATAWIDTH-1:0]         rsp_diff;
`ifdef SUB_ARBITER_BORROW_EN
    logic                         rsp_borrow;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow
    );
`else
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_diff
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_diff
    );
`endif

endinterface

// File: rtl/SUB.sv
// -----------------------------------------------------------------------------
// SUB
// The datapath's shared subtractor, purely combinational.
//   a, b : operands (DATAWIDTH bits)
//   diff : a - b modulo 2^DATAWIDTH
// -----------------------------------------------------------------------------
module SUB #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] diff
);

    assign diff = a - b;

endmodule

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Picks the first set bit of req_valid
// searching upward from ptr and wrapping past NUM_REQ-1 back to 0.
//   req_valid : request vector
//   ptr       : highest-priority index this round
//   grant     : one-hot grant (all-zero if no request)
//   grant_idx : index of the granted requester (0 if none)
//   grant_any : at least one request present
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_any
);

    int dist_s;
    int best_dist_s;

    // Each requester's distance from ptr in the wrap-around order; the
    // closest valid one wins, which is exactly "first set bit from ptr".
    always_comb begin
        best_dist_s = NUM_REQ;
        dist_s      = 0;
        grant_idx   = {IDW{1'b0}};
        grant_any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(ptr) <= i) begin
                dist_s = i - int'(ptr);
            end else begin
                dist_s = i + NUM_REQ - int'(ptr);
            end
            if (req_valid[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                grant_idx   = IDW'(i);
                grant_any   = 1'b1;
            end else begin
                grant_any   = grant_any;
            end
        end
    end

    // Expand the winning index to a one-hot vector.
    always_comb begin
        if (grant_any) begin
            grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
        end else begin
            grant = {NUM_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/sub_arbiter.sv
// -----------------------------------------------------------------------------
// sub_arbiter
// Round-robin arbiter/sequencer sharing one SUB among NUM_REQ requesters.
// IDLE grants one requester (req_ready asserted combinationally, operands
// latched), EXEC registers the SUB result, RESP holds rsp_valid until
// rsp_ready; priority then moves to the requester after the one served.
// One operation per 3 cycles with rsp_ready held high.
//   Clk  : clock, rising edge
//   Rst  : synchronous active-high reset, aborts any in-flight transaction
//   bus  : sub_arbiter_if.slave (request and response handshakes)
// Optional feature: define SUB_ARBITER_BORROW_EN to add bus.rsp_borrow,
// registered in EXEC as unsigned a < b and valid alongside rsp_diff.
// -----------------------------------------------------------------------------
module sub_arbiter
    import sub_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int IDW       = id_width(NUM_REQ)
) (
    input  logic          Clk,
    input  logic          Rst,
    sub_arbiter_if.slave  bus
);

    state_e               state_r;
    state_e               state_nxt_s;
    logic [IDW-1:0]       ptr_r;
    logic [IDW-1:0]       ptr_nxt_s;
    logic [IDW-1:0]       id_r;
    logic [DATAWIDTH-1:0] a_r;
    logic [DATAWIDTH-1:0] b_r;
    logic [DATAWIDTH-1:0] diff_r;
    logic                 rsp_valid_r;

    logic [NUM_REQ-1:0]   grant_s;
    logic [IDW-1:0]       grant_idx_s;
    logic                 any_s;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic [DATAWIDTH-1:0] a_sel_s;
    logic [DATAWIDTH-1:0] b_sel_s;
    logic [DATAWIDTH-1:0] sub_diff_s;
    logic                 latch_s;
    logic                 accept_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req_valid (bus.req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (any_s)
    );

    SUB #(
        .DATAWIDTH (DATAWIDTH)
    ) u_sub (
        .a    (a_r),
        .b    (b_r),
        .diff (sub_diff_s)
    );

    // One-hot operand mux driven by the picker's grant vector.
    always_comb begin
        a_sel_s = {DATAWIDTH{1'b0}};
        b_sel_s = {DATAWIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                a_sel_s = bus.req_a[i*DATAWIDTH +: DATAWIDTH];
                b_sel_s = bus.req_b[i*DATAWIDTH +: DATAWIDTH];
            end else begin
                a_sel_s = a_sel_s;
            end
        end
    end

    // Next-state and handshake decode. req_ready is held low while Rst is
    // high: the latch would be overridden by reset, so no transfer may be
    // signalled. rsp_ready only steers state, never req_ready.
    always_comb begin
        state_nxt_s = state_r;
        req_ready_s = {NUM_REQ{1'b0}};
        latch_s     = 1'b0;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_s && !Rst) begin
                    req_ready_s = grant_s;
                    latch_s     = 1'b1;
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Priority after a completed transaction: the requester after id_r.
    always_comb begin
        if (id_r == IDW'(NUM_REQ - 1)) begin
            ptr_nxt_s = {IDW{1'b0}};
        end else begin
            ptr_nxt_s = id_r + IDW'(1'b1);
        end
    end

    // State, pointer, operand and result registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IDW{1'b0}};
            id_r        <= {IDW{1'b0}};
            a_r         <= {DATAWIDTH{1'b0}};
            b_r         <= {DATAWIDTH{1'b0}};
            diff_r      <= {DATAWIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            if (latch_s) begin
                a_r  <= a_sel_s;
                b_r  <= b_sel_s;
                id_r <= grant_idx_s;
            end
            if (state_r == ST_EXEC) begin
                diff_r <= sub_diff_s;
            end
            if (accept_s) begin
                ptr_r <= ptr_nxt_s;
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = id_r;
    assign bus.rsp_diff  = diff_r;

`ifdef SUB_ARBITER_BORROW_EN
    logic borrow_r;

    // Borrow flag captured alongside the difference.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            borrow_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            borrow_r <= (a_r < b_r);
        end
    end

    assign bus.rsp_borrow = borrow_r;
`endif

endmodule

// File: tb/tb_sub_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sub_arbiter
// Scoreboard bench for sub_arbiter (DATAWIDTH=8, NUM_REQ=4). A reference
// model predicts grants from the round-robin rule and pushes expected results
// into a queue; a separate monitor compares every presented response.
// -----------------------------------------------------------------------------
module tb_sub_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    typedef struct {
        int         id;
        logic [7:0] diff;
        logic       borrow;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic last_rst = 1'b1;

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];

    // reference-model state
    bit m_busy = 1'b0;
    int m_age  = 0;
    int m_ptr  = 0;
    int m_id   = 0;

    sub_arbiter_if #(.DATAWIDTH(DW), .NUM_REQ(NR)) bus ();

    sub_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) last_rst <= rst;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // First requesting index at or after p, wrapping; -1 when none.
    function automatic int first_from(input logic [3:0] v, input int p);
        int k;
        for (int off = 0; off < NR; off++) begin
            k = (p + off) % NR;
            if (v[k[1:0]]) return k;
        end
        return -1;
    endfunction

    // Reference model: a free arbiter grants the round-robin winner; a
    // result appears two cycles after its grant and frees the arbiter when
    // accepted; reset discards everything in flight.
    always @(negedge clk) begin
        int         pick;
        logic [3:0] exp_ready;
        bit         exp_valid;
        logic [7:0] a;
        logic [7:0] b;
        #1;
        if (m_busy) m_age++;
        exp_valid = m_busy && (m_age >= 2);
        check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_valid});
        pick      = (!rst && !m_busy) ? first_from(bus.req_valid, m_ptr) : -1;
        exp_ready = (pick >= 0) ? 4'(4'b0001 << pick) : 4'b0000;
        check("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_ready});
        if (last_rst) begin
            check("reset_rsp_id", {30'd0, bus.rsp_id}, 32'd0);
            check("reset_rsp_diff", {24'd0, bus.rsp_diff}, 32'd0);
        end
        if (rst) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_ptr  = 0;
            exp_q.delete();
        end else if (pick >= 0) begin
            a = bus.req_a[pick*DW +: DW];
            b = bus.req_b[pick*DW +: DW];
            exp_q.push_back('{id: pick, diff: 8'(a - b), borrow: (a < b)});
            m_busy = 1'b1;
            m_age  = 0;
            m_id   = pick;
        end else if (exp_valid && bus.rsp_ready) begin
            m_busy = 1'b0;
            m_ptr  = (m_id + 1) % NR;
        end
    end

    // Monitor: every presented response must match the oldest expectation;
    // it is retired only when accepted.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                note_fail("rsp_unexpected");
            end else begin
                e = exp_q[0];
                check("rsp_id", {30'd0, bus.rsp_id}, 32'(e.id));
                check("rsp_diff", {24'd0, bus.rsp_diff}, {24'd0, e.diff});
`ifdef SUB_ARBITER_BORROW_EN
                check("rsp_borrow", {31'd0, bus.rsp_borrow}, {31'd0, e.borrow});
`endif
                if (bus.rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic setop(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
    endtask

    // Raise the masked requests and drop each one after its handshake.
    task automatic serve(input logic [3:0] mask);
        logic [3:0] pending;
        logic [3:0] done;
        pending       = mask;
        bus.req_valid = pending;
        for (int c = 0; c < 60 && pending != 4'b0000; c++) begin
            @(negedge clk);
            done = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            pending       = pending & ~done;
            bus.req_valid = pending;
        end
        if (pending != 4'b0000) note_fail("serve_timeout");
    endtask

    task automatic wait_rsp();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = (bus.rsp_valid === 1'b1);
        end
        if (!seen) note_fail("rsp_timeout");
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && (exp_q.size() != 0 || m_busy); c++) @(negedge clk);
        @(posedge clk);
        #1;
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a     = 32'h0;
        bus.req_b     = 32'h0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b1;

        // single request and wrap-around arithmetic
        setop(0, 8'd10, 8'd0);
        serve(4'b0001);
        drain();
        setop(1, 8'd15, 8'd20);
        serve(4'b0010);
        drain();
        setop(2, 8'd15, 8'd5);
        serve(4'b0100);
        drain();

        // fairness with all four requesting from ptr=0
        pulse_reset();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < NR; i++) setop(i, 8'($urandom), 8'($urandom));
            @(posedge clk);
            #1;
        end
        bus.req_valid = 4'b0000;
        drain();

        // backpressure: five stalled cycles with another request waiting
        bus.rsp_ready = 1'b0;
        setop(0, 8'd200, 8'd55);
        serve(4'b0001);
        setop(1, 8'd1, 8'd2);
        bus.req_valid = 4'b0010;
        wait_rsp();
        repeat (5) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        serve(4'b0010);
        drain();

        // reset while req3's result is being presented
        bus.rsp_ready = 1'b0;
        setop(3, 8'd99, 8'd33);
        serve(4'b1000);
        wait_rsp();
        pulse_reset();
        bus.rsp_ready = 1'b1;
        setop(2, 8'd7, 8'd9);
        setop(3, 8'd50, 8'd1);
        serve(4'b1100);
        drain();

        // randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.req_a     = $urandom();
            bus.req_b     = $urandom();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_arbiter.md
# sub_arbiter

Round-robin arbiter and sequencer that shares a single `SUB` subtractor among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, latches its operands, drives the shared `SUB`, registers the difference and returns it with the requester ID over a valid/ready response port. It sits between the datapath clients and the one `SUB` instance in the datapath.

## Interface
- `DATAWIDTH`, 8: operand and result width in bits.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(NUM_REQ)`: requester ID width.

- `Clk`  in  1  single clock; all logic on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester operand valid.
- `req_ready`  out  `NUM_REQ`  per-requester grant/accept; at most one bit set.
- `req_a`  in  `NUM_REQ*DATAWIDTH`  minuends, flattened; requester i at `[i*DATAWIDTH +: DATAWIDTH]`.
- `req_b`  in  `NUM_REQ*DATAWIDTH`  subtrahends, same packing.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  downstream accepts result.
- `rsp_id`  out  `IDW`  index of the served requester.
- `rsp_diff`  out  `DATAWIDTH`  `a - b` modulo 2^`DATAWIDTH`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit searching upward from `ptr` and wrapping.
  - Assert that requester's `req_ready` combinationally in the same cycle. The transfer happens in that cycle.
  - Latch `a_q`, `b_q` and `id_q`, then go to EXEC.
  - With no request, stay in IDLE.
- **EXEC**
  - `SUB` is fed `a_q`/`b_q`.
  - Its output is registered into `diff_q`. Go to RESP.
- **RESP**
  - `rsp_valid`=1.
  - When `rsp_ready`=1: go to IDLE and set `ptr` = `id_q`+1, wrapping from `NUM_REQ`-1 to 0.
  - Otherwise hold.
- `req_ready` is all-zero in EXEC and RESP. New requests wait there and are arbitrated on return to IDLE.
- Arithmetic: `rsp_diff` wraps modulo 2^`DATAWIDTH`. There is no saturation. Example: 15-20 at 8 bits gives 251.
- `rsp_id`/`rsp_diff` are driven from `id_q`/`diff_q`. They are stable throughout RESP.
- Requesters may drop `req_valid` at any time without penalty. Nothing is committed until `req_ready` is high.
- Reset values: state=IDLE, `ptr`=0, `a_q`=`b_q`=`diff_q`=0, `id_q`=0, `rsp_valid`=0, `req_ready`=0, `rsp_id`=0, `rsp_diff`=0.
- `Rst` asserted in any state aborts the in-flight transaction. The result is discarded and never presented.

## Timing
- Cycle N (IDLE): grant plus operand latch.
- Cycle N+1 (EXEC): subtract, registered.
- Cycle N+2: `rsp_valid`=1, the earliest accept.
- Back-to-back throughput is one operation per 3 cycles with `rsp_ready` tied high. The next grant is at N+3.
- Backpressure: each cycle with `rsp_ready`=0 in RESP adds one cycle. No outputs change during the stall.
- Reset: `Rst` sampled high at edge E leaves all outputs at reset values after E. The first grant is possible in the cycle after `Rst` deasserts.
- No combinational path from `rsp_ready` to `req_ready`. `req_ready` depends only on state, `ptr` and `req_valid`.

## Configuration
- Macro `SUB_ARBITER_BORROW_EN`.
- Defined:
  - Adds output `rsp_borrow` (out, 1), registered in EXEC as `a_q < b_q` (unsigned).
  - Valid with `rsp_diff`; reset value 0.
- Undefined: the port and its register do not exist. Behaviour is otherwise identical.

## Structure
- Shared package `sub_arbiter_pkg` holds:
  - the state encoding constants (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - the ID-width function.
- One sub-module, `rr_picker`.
  - It is purely combinational.
  - It takes `req_valid` and `ptr` and returns a one-hot grant plus the grant index.
- The existing `SUB` is instantiated unchanged as the datapath.

## Test plan
Each scenario uses `DATAWIDTH`=8 and `NUM_REQ`=4.
- Reset: `Rst` high 2 cycles with all `req_valid` set -> `req_ready`=0, `rsp_valid`=0, `rsp_diff`=0, `rsp_id`=0 throughout.
- Single request: req0 a=10, b=0 -> `req_ready[0]`=1 in cycle N; `rsp_valid`=1 at N+2 with `rsp_diff`=10, `rsp_id`=0.
- Underflow: req1 a=15, b=20 -> `rsp_diff`=251, `rsp_id`=1; `rsp_borrow`=1 with the macro defined. Also req2 a=15, b=5 -> 10, borrow 0.
- Fairness: all four `req_valid` held high, `rsp_ready`=1 -> `rsp_id` sequence 0,1,2,3,0 with grants 3 cycles apart.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP -> `rsp_valid`/`rsp_id`/`rsp_diff` constant and `req_ready`=0. The result is accepted on the first cycle `rsp_ready`=1.
- Reset mid-op: `Rst` pulsed while in RESP for req3 -> `rsp_valid`=0 the next cycle and that result is never presented. With `ptr` back to 0, req2 and req3 then requesting together -> req2 granted first.
